rx_dc_offset_track: RTL and testbench
=====================================

// Module: rx_dc_offset_track
//
// PURPOSE
// Tracks and removes DC offset from one real sample stream (one instance per I or Q rail).
// Sits in the RX frontend directly upstream of the IQ-balance mult_add_clip stage.
// Subtracts a running DC estimate from each input sample and saturates the result.
// The estimate is a leaky integrator of the corrected output; it can be frozen or
// preloaded through a settings word.
//
// PARAMETERS
// WIDTH        24  sample width, signed two's complement, 2..30
// ALPHA_SHIFT  20  integrator shift; loop gain = 2^-ALPHA_SHIFT, 1..31
// (localparam) ACC_W = WIDTH+ALPHA_SHIFT  accumulator width
//
// PORTS
// clk       in   1      clock
// reset     in   1      asynchronous, active-high reset
// set_stb   in   1      settings write strobe, one cycle
// set_data  in   32     [31] track_en, [30] load, [WIDTH-1:0] signed estimate to load
// in_stb    in   1      input sample valid
// in        in   WIDTH  input sample, signed
// out_stb   out  1      output sample valid
// out       out  WIDTH  corrected, saturated sample, signed
// est       out  WIDTH  current DC estimate (acc >>> ALPHA_SHIFT)
//
// BEHAVIOUR
// - Reset (async assert, sync release): acc=0, track_en=0, out=0, out_stb=0, est=0, pipeline flushed.
// - Pipeline, latency 2 cycles, no backpressure:
//   - S1 (in_stb): d1 <= in - est, computed at WIDTH+1 bits.
//   - S2: out <= clip(d1) to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; out_stb = in_stb delayed 2 cycles.
// - Gapped in_stb is legal. out and est hold their values between strobes.
// - Integrator: in the cycle S2 holds a valid sample and track_en=1:
//   acc <= sat_ACC_W(acc + sext(clip(d1))).
//   - acc saturates at +/-2^(ACC_W-1); it does not wrap, so est stays within the WIDTH range.
//   - est uses arithmetic shift (floor).
// - track_en=0: acc frozen; block is a fixed-offset subtractor.
// - set_stb: track_en <= set_data[31].
//   - If set_data[30]=1: acc <= sext(set_data[WIDTH-1:0]) << ALPHA_SHIFT.
//   - load=0 leaves acc unchanged.
// - Simultaneous set_stb(load) and S2 accumulate: the load wins and that sample's accumulation is dropped.
//   - Samples already in S1 keep the estimate they sampled (the old est).
// - The new track_en applies to accumulations from the next cycle onward.
// - Reset mid-stream: in-flight samples are discarded; no out_stb is produced for them.
//
// TESTING (WIDTH=24, ALPHA_SHIFT=4 unless noted)
// 1. Reset released, track off, in=0x123456 strobed once
//    -> out_stb exactly 2 cycles later, out=0x123456, est=0.
// 2. set_data=0x4000_0100 (load 0x100, track off), in=0x000300
//    -> out=0x000200, est=0x000100.
// 3. Saturation, two cases:
//    - load est=0x000100, in=0x800000 -> out=0x800000.
//    - load est=0xFFFF00, in=0x7FFFFF -> out=0x7FFFFF.
// 4. Track on (set_data=0x8000_0000), in=0x000100 every cycle
//    -> out decreases monotonically, reaches 0x000000 within 300 samples and stays there; est=0x000100.
// 5. Freeze and gaps:
//    - Same as 4, then set_data=0 -> est constant; in=0x000180 -> out=0x000080.
//    - in_stb every 3rd cycle -> acc changes only on strobes.
// 6. Collisions and reset:
//    - set_stb load 0 in the same cycle S2 is valid with track on -> acc=0 next cycle.
//    - reset asserted mid-stream -> out, out_stb, est go to 0 immediately (async).

Source files
------------

// File: rtl/rx_dc_offset_track.sv
// DC offset tracker for one real RX rail.
// Subtracts a leaky-integrator estimate from each sample and saturates the result.
module rx_dc_offset_track #(
    parameter int WIDTH       = 24,
    parameter int ALPHA_SHIFT = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_stb,
    input  logic [31:0]      set_data,
    input  logic             in_stb,
    input  logic [WIDTH-1:0] in,
    output logic             out_stb,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] est
);

    localparam int ACC_W = WIDTH + ALPHA_SHIFT;

    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic             track_en;
    logic             v1;
    logic [WIDTH:0]   d1;
    logic [WIDTH-1:0] d1_clip;
    logic [ACC_W-1:0] acc;
    logic [ACC_W:0]   acc_sum;
    logic [ACC_W-1:0] acc_sat;
    logic [ACC_W-1:0] acc_load;
    logic             unused_set_bits;

    assign unused_set_bits = ^set_data[29:0];

    // Floor of acc / 2^ALPHA_SHIFT is simply the top WIDTH bits.
    assign est = acc[ACC_W-1:ALPHA_SHIFT];

    assign acc_load = {set_data[WIDTH-1:0], {ALPHA_SHIFT{1'b0}}};

    always_comb begin
        d1_clip = d1[WIDTH-1:0];
        if (d1[WIDTH] != d1[WIDTH-1]) begin
            d1_clip = d1[WIDTH] ? SMIN : SMAX;
        end
    end

    always_comb begin
        acc_sum = {acc[ACC_W-1], acc}
                + {{(ALPHA_SHIFT+1){d1_clip[WIDTH-1]}}, d1_clip};
        acc_sat = acc_sum[ACC_W-1:0];
        if (acc_sum[ACC_W] != acc_sum[ACC_W-1]) begin
            acc_sat = {acc_sum[ACC_W], {(ACC_W-1){~acc_sum[ACC_W]}}};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1       <= 1'b0;
            d1       <= '0;
            out_stb  <= 1'b0;
            out      <= '0;
            track_en <= 1'b0;
            acc      <= '0;
        end else begin
            v1      <= in_stb;
            out_stb <= v1;
            if (in_stb) begin
                d1 <= {in[WIDTH-1], in} - {est[WIDTH-1], est};
            end
            if (v1) begin
                out <= d1_clip;
            end
            if (set_stb) begin
                track_en <= set_data[31];
            end
            // A load overrides the accumulation of the sample leaving S2.
            if (set_stb && set_data[30]) begin
                acc <= acc_load;
            end else if (v1 && track_en) begin
                acc <= acc_sat;
            end
        end
    end

endmodule

// File: tb/tb_rx_dc_offset_track.sv
// Directed scoreboard bench for rx_dc_offset_track.
// WIDTH=24, ALPHA_SHIFT=4.
module tb_rx_dc_offset_track;

    logic        clk;
    logic        reset;
    logic        set_stb;
    logic [31:0] set_data;
    logic        in_stb;
    logic [23:0] in;
    logic        out_stb;
    logic [23:0] out;
    logic [23:0] est;

    int n_assert = 0;
    int n_fail   = 0;
    bit sb_on    = 1'b1;

    logic [23:0] q[$];
    logic [23:0] trk[$];

    rx_dc_offset_track #(.WIDTH(24), .ALPHA_SHIFT(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .set_stb  (set_stb),
        .set_data (set_data),
        .in_stb   (in_stb),
        .in       (in),
        .out_stb  (out_stb),
        .out      (out),
        .est      (est)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic sample(input logic [23:0] v);
        in_stb = 1'b1;
        in     = v;
        tick();
        in_stb = 1'b0;
    endtask

    task automatic setw(input logic [31:0] d);
        set_stb  = 1'b1;
        set_data = d;
        tick();
        set_stb  = 1'b0;
    endtask

    initial begin : monitor
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (!reset && out_stb) begin
                if (!sb_on) begin
                    trk.push_back(out);
                end else if (q.size() == 0) begin
                    check("sb_unexpected", q.size(), 1);
                end else begin
                    e = q.pop_front();
                    check("sb_out", out, e);
                end
            end
        end
    end

    initial begin : stim
        int acc_m;
        int e;
        int bad;
        int first_zero;

        reset    = 1'b1;
        set_stb  = 1'b0;
        set_data = '0;
        in_stb   = 1'b0;
        in       = '0;
        repeat (3) tick();
        check("rst_out", out, 0);
        check("rst_out_stb", out_stb, 0);
        check("rst_est", est, 0);
        reset = 1'b0;
        tick();

        // Pass-through latency with estimate at zero
        q.push_back(24'h123456);
        in_stb = 1'b1;
        in     = 24'h123456;
        tick();
        in_stb = 1'b0;
        check("lat_c1", out_stb, 0);
        tick();
        check("lat_c2", out_stb, 1);
        check("lat_est", est, 0);
        tick();
        check("lat_c3", out_stb, 0);

        setw(32'h4000_0100);
        check("load_est", est, 24'h000100);
        q.push_back(24'h000200);
        sample(24'h000300);
        repeat (3) tick();

        q.push_back(24'h800000);
        sample(24'h800000);
        repeat (3) tick();
        setw(32'h40FF_FF00);
        check("load_neg_est", est, 24'hFFFF00);
        q.push_back(24'h7FFFFF);
        sample(24'h7FFFFF);
        repeat (3) tick();

        // Closed-loop convergence, outputs captured outside the scoreboard
        setw(32'hC000_0000);
        check("trk_est0", est, 0);
        sb_on = 1'b0;
        trk.delete();
        in_stb = 1'b1;
        in     = 24'h000100;
        repeat (300) tick();
        in_stb = 1'b0;
        repeat (3) tick();
        check("trk_count", trk.size(), 300);
        check("trk_first", trk[0], 24'h000100);
        bad = 0;
        first_zero = -1;
        for (int i = 0; i < trk.size(); i++) begin
            if (i > 0 && trk[i] > trk[i-1]) bad++;
            if (first_zero < 0 && trk[i] == 0) first_zero = i;
            if (first_zero >= 0 && trk[i] != 0) bad++;
        end
        check("trk_mono_stay", bad, 0);
        check("trk_reached", first_zero >= 0 && first_zero < 300, 1);
        check("trk_est", est, 24'h000100);
        sb_on = 1'b1;

        setw(32'h0000_0000);
        check("frz_est", est, 24'h000100);
        q.push_back(24'h000080);
        sample(24'h000180);
        repeat (3) tick();
        check("frz_est2", est, 24'h000100);

        // Gapped strobes with tracking: sequential integrator model
        setw(32'hC000_0100);
        acc_m = 32'h1000;
        for (int i = 0; i < 6; i++) begin
            e = 32'h200 - (acc_m >>> 4);
            q.push_back(e[23:0]);
            acc_m += e;
            sample(24'h000200);
            tick();
            check("gap_est_a", est, (acc_m >>> 4) & 32'hFFFFFF);
            tick();
            check("gap_est_b", est, (acc_m >>> 4) & 32'hFFFFFF);
        end

        // Load colliding with an S2 accumulation
        e = 32'h100 - (acc_m >>> 4);
        q.push_back(e[23:0]);
        in_stb = 1'b1;
        in     = 24'h000100;
        tick();
        in_stb   = 1'b0;
        set_stb  = 1'b1;
        set_data = 32'hC000_0000;
        tick();
        set_stb = 1'b0;
        check("col_est", est, 0);
        tick();
        check("col_est_hold", est, 0);
        q.push_back(24'h000050);
        sample(24'h000050);
        tick();
        check("col_track", est, 24'h000005);

        // Load in the same cycle a sample enters S1
        q.push_back(24'h0000FB);
        in_stb   = 1'b1;
        in       = 24'h000100;
        set_stb  = 1'b1;
        set_data = 32'h4000_0040;
        tick();
        in_stb  = 1'b0;
        set_stb = 1'b0;
        check("s1_load_est", est, 24'h000040);
        repeat (2) tick();
        check("s1_frozen", est, 24'h000040);
        check("sb_drained", q.size(), 0);

        // Asynchronous reset while streaming
        sb_on  = 1'b0;
        in_stb = 1'b1;
        in     = 24'h000100;
        repeat (3) tick();
        check("mid_out", out, 24'h0000C0);
        check("mid_stb", out_stb, 1);
        #2 reset = 1'b1;
        #1;
        check("arst_out", out, 0);
        check("arst_stb", out_stb, 0);
        check("arst_est", est, 0);
        tick();
        in_stb = 1'b0;
        tick();
        trk.delete();
        reset = 1'b0;
        repeat (3) tick();
        check("arst_flush", trk.size(), 0);
        check("arst_est_post", est, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
